// File: rtl/spi_slave.sv
// Mode-0, MSB-first byte-oriented SPI responder with oversampled pins and a valid/ready tx port.
// Optional one-entry transmit holding register: define SPI_SLAVE_TXBUF_EN.
module spi_slave #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss_n_i,
   input  logic       sck_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       busy_o,
   output logic       underrun_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

   logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
   logic                   ss_hist_q, sck_hist_q, mosi_hist_q;
   logic                   sel_fall_q, sel_rise_q, sck_rise_q, sck_fall_q;

   state_e      state_q;
   logic [2:0]  cnt_q;
   logic [7:0]  tx_sh_q;
   logic [6:0]  rx_sh_q;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q, underrun_q, miso_q, oe_q;

   logic        load_s;
   logic [7:0]  tx_byte_s;
   logic        underrun_d;

`ifdef SPI_SLAVE_TXBUF_EN
   logic [7:0]  hold_q;
   logic        hold_empty_q;
`endif

   // Pin synchronizers plus one history stage; edge pulses are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync_q   <= {SYNC_STAGES{1'b1}};
         sck_sync_q  <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         ss_hist_q   <= 1'b1;
         sck_hist_q  <= 1'b0;
         mosi_hist_q <= 1'b0;
         sel_fall_q  <= 1'b0;
         sel_rise_q  <= 1'b0;
         sck_rise_q  <= 1'b0;
         sck_fall_q  <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
         sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
         mosi_hist_q <= mosi_sync_q[SYNC_STAGES-1];
         sel_fall_q  <= ss_hist_q & ~ss_sync_q[SYNC_STAGES-1];
         sel_rise_q  <= ~ss_hist_q & ss_sync_q[SYNC_STAGES-1];
         sck_rise_q  <= ~sck_hist_q & sck_sync_q[SYNC_STAGES-1];
         sck_fall_q  <= sck_hist_q & ~sck_sync_q[SYNC_STAGES-1];
      end
   end

   // Load-point detection and tx source selection.
   always_comb begin
      load_s     = 1'b0;
      tx_byte_s  = DEFAULT_TX;
      underrun_d = 1'b0;
      case (state_q)
         IDLE:    load_s = sel_fall_q;
         ACTIVE:  load_s = sck_fall_q & ~sel_rise_q & (cnt_q == 3'd0);
         default: load_s = 1'b0;
      endcase
`ifdef SPI_SLAVE_TXBUF_EN
      if (!hold_empty_q) begin
         tx_byte_s = hold_q;
      end else if (tx_valid_i) begin
         tx_byte_s = tx_data_i;
      end else begin
         underrun_d = load_s;
      end
`else
      if (tx_valid_i) begin
         tx_byte_s = tx_data_i;
      end else begin
         underrun_d = load_s;
      end
`endif
   end

`ifdef SPI_SLAVE_TXBUF_EN
   // Holding register: drained by a load, refilled only when no load competes (bypass wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= 8'h00;
         hold_empty_q <= 1'b1;
      end else if (load_s && !hold_empty_q) begin
         hold_empty_q <= 1'b1;
      end else if (tx_valid_i && hold_empty_q && !load_s) begin
         hold_q       <= tx_data_i;
         hold_empty_q <= 1'b0;
      end
   end

   assign tx_ready_o = hold_empty_q;
`else
   assign tx_ready_o = load_s;
`endif

   // Transfer FSM; a deselect takes priority over a coincident sck edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         tx_sh_q    <= 8'h00;
         rx_sh_q    <= 7'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= underrun_d;
         case (state_q)
            IDLE: begin
               if (sel_fall_q) begin
                  state_q <= ACTIVE;
                  oe_q    <= 1'b1;
                  miso_q  <= tx_byte_s[7];
                  tx_sh_q <= {tx_byte_s[6:0], 1'b0};
                  if (sck_rise_q) begin
                     rx_sh_q <= {rx_sh_q[5:0], mosi_hist_q};
                     cnt_q   <= 3'd1;
                  end else begin
                     cnt_q   <= 3'd0;
                  end
               end else begin
                  miso_q <= 1'b0;
                  oe_q   <= 1'b0;
                  cnt_q  <= 3'd0;
               end
            end
            ACTIVE: begin
               if (sel_rise_q) begin
                  state_q <= IDLE;
                  oe_q    <= 1'b0;
                  miso_q  <= 1'b0;
                  cnt_q   <= 3'd0;
               end else if (sck_rise_q) begin
                  rx_sh_q <= {rx_sh_q[5:0], mosi_hist_q};
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rx_data_q  <= {rx_sh_q, mosi_hist_q};
                     rx_valid_q <= 1'b1;
                  end
               end else if (load_s) begin
                  miso_q  <= tx_byte_s[7];
                  tx_sh_q <= {tx_byte_s[6:0], 1'b0};
               end else if (sck_fall_q) begin
                  miso_q  <= tx_sh_q[7];
                  tx_sh_q <= {tx_sh_q[6:0], 1'b0};
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign miso_o     = miso_q;
   assign miso_oe_o  = oe_q;
   assign busy_o     = oe_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign underrun_o = underrun_q;

endmodule
